result_mux: RTL and testbench

RESULT_MUX -- requirements
Module: result_mux

---
 rtl/result_mux_pkg.sv | 21 ++
 rtl/result_mux_if.sv | 27 ++
 rtl/param_def.sv | 7 +
 rtl/result_mux_result_reg.sv | 31 +++
 rtl/result_mux.sv | 104 ++++++++++
 tb/tb_result_mux.sv | 267 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/result_mux_pkg.sv
// Shared types and defaults for the result merge path.
`include "param_def.sv"

package result_mux_pkg;

  localparam int MAC_BW_DEF = `MAC_BW;
  localparam int LANES_DEF  = 64;

  typedef enum logic [1:0] {
    MODE_MAC = 2'd0,
    MODE_DIV = 2'd1,
    MODE_EXP = 2'd2,
    MODE_LOG = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

endpackage

// File: rtl/result_mux_if.sv
// Bundle of per-unit result streams, the merged output stream and status.
interface result_mux_if #(
  parameter int MAC_BW = result_mux_pkg::MAC_BW_DEF,
  parameter int LANES  = result_mux_pkg::LANES_DEF
);
  logic [1:0]                   mode;
  logic [LANES-1:0][MAC_BW-1:0] oC_mac, oC_div, oC_exp, oC_log;
  logic                         v_mac, v_div, v_exp, v_log;
  logic                         r_mac, r_div, r_exp, r_log;
  logic [LANES-1:0][MAC_BW-1:0] oC;
  logic                         oC_valid;
  logic                         oC_ready;
  logic [1:0]                   mode_q;
  logic                         switch_pend;
  logic                         stray_err;
  logic [15:0]                  res_cnt;

  modport master (
    output mode, oC_mac, oC_div, oC_exp, oC_log, v_mac, v_div, v_exp, v_log, oC_ready,
    input  r_mac, r_div, r_exp, r_log, oC, oC_valid, mode_q, switch_pend, stray_err, res_cnt
  );

  modport slave (
    input  mode, oC_mac, oC_div, oC_exp, oC_log, v_mac, v_div, v_exp, v_log, oC_ready,
    output r_mac, r_div, r_exp, r_log, oC, oC_valid, mode_q, switch_pend, stray_err, res_cnt
  );
endinterface

// File: rtl/param_def.sv
// Global datapath widths shared by the arithmetic units and the result path.
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV
`ifndef MAC_BW
`define MAC_BW 16
`endif
`endif

// File: rtl/result_mux_result_reg.sv
// One-entry valid/ready output register, 1-cycle latency, full throughput.
// Accepts new data when empty or when the held entry drains in the same cycle.
module result_reg #(
  parameter int MAC_BW = result_mux_pkg::MAC_BW_DEF,
  parameter int LANES  = result_mux_pkg::LANES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [LANES-1:0][MAC_BW-1:0] in_dat,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [LANES-1:0][MAC_BW-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld <= 1'b1;
      out_dat <= in_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/result_mux.sv
// Routes one of four unit result streams into a registered output, 1-cycle latency.
// Only the routed unit sees ready; mode changes wait until the output register drains.
module result_mux
  import result_mux_pkg::*;
#(
  parameter int MAC_BW = MAC_BW_DEF,
  parameter int LANES  = LANES_DEF
) (
  input logic        clk,
  input logic        rst,
  result_mux_if.slave bus
);

  typedef logic [LANES-1:0][MAC_BW-1:0] lanes_t;

  state_t     state_q, state_d;
  mode_t      mode_q, mode_req;
  logic       load_mode, route_en;
  logic       sel_vld, rdy_sel, capture, stray_hit;
  logic [3:0] vld_vec, rdy_vec, sel_mask;
  lanes_t     sel_dat, out_dat;
  logic       out_vld, reg_in_rdy;
  logic       stray_q;
  logic [15:0] cnt_q;

  assign mode_req = mode_t'(bus.mode);
  assign vld_vec  = {bus.v_log, bus.v_exp, bus.v_div, bus.v_mac};
  assign sel_mask = 4'(1) << mode_q;

  always_comb begin
    sel_dat = bus.oC_mac;
    case (mode_q)
      MODE_MAC: sel_dat = bus.oC_mac;
      MODE_DIV: sel_dat = bus.oC_div;
      MODE_EXP: sel_dat = bus.oC_exp;
      MODE_LOG: sel_dat = bus.oC_log;
      default:  sel_dat = bus.oC_mac;
    endcase
  end

  assign sel_vld = |(vld_vec & sel_mask);

  // A pending mode change closes the route in the same cycle it is seen.
  always_comb begin
    state_d   = state_q;
    load_mode = 1'b0;
    route_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_req != mode_q) state_d = ST_SWITCH;
        else                    route_en = 1'b1;
      end
      ST_SWITCH: begin
        if (!out_vld) begin
          state_d   = ST_RUN;
          load_mode = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign rdy_sel   = route_en && reg_in_rdy && !rst;
  assign rdy_vec   = rdy_sel ? sel_mask : 4'b0000;
  assign capture   = rdy_sel && sel_vld;
  assign stray_hit = (state_q == ST_RUN) && |(vld_vec & ~sel_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_MAC;
      stray_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (load_mode) mode_q <= mode_req;
      if (stray_hit) stray_q <= 1'b1;
      if (out_vld && bus.oC_ready) cnt_q <= cnt_q + 16'd1;
    end
  end

  result_reg #(.MAC_BW(MAC_BW), .LANES(LANES)) u_result_reg (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (capture),
    .in_rdy  (reg_in_rdy),
    .in_dat  (sel_dat),
    .out_vld (out_vld),
    .out_rdy (bus.oC_ready),
    .out_dat (out_dat)
  );

  assign bus.r_mac       = rdy_vec[0];
  assign bus.r_div       = rdy_vec[1];
  assign bus.r_exp       = rdy_vec[2];
  assign bus.r_log       = rdy_vec[3];
  assign bus.oC          = out_dat;
  assign bus.oC_valid    = out_vld;
  assign bus.mode_q      = mode_q;
  assign bus.switch_pend = (state_q == ST_SWITCH);
  assign bus.stray_err   = stray_q;
  assign bus.res_cnt     = cnt_q;

endmodule

// File: tb/tb_result_mux.sv
// Scenario bench for result_mux with a scoreboard of captured results.
module tb_result_mux;
  import result_mux_pkg::*;

  localparam int BW = MAC_BW_DEF;
  localparam int LN = LANES_DEF;
  typedef logic [LN-1:0][BW-1:0] lanes_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_mux_if #(.MAC_BW(BW), .LANES(LN)) mif ();

  result_mux #(.MAC_BW(BW), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  int     checks = 0;
  int     errors = 0;
  lanes_t sb[$];
  bit     mon_on = 1'b0;

  function automatic lanes_t mk(int unit, int seq);
    lanes_t d;
    for (int i = 0; i < LN; i++) d[i] = BW'(seq + i * 7 + unit * 1000);
    return d;
  endfunction

  function automatic logic [3:0] rdys();
    return {mif.r_log, mif.r_exp, mif.r_div, mif.r_mac};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mif.v_mac = 1'b0; mif.v_div = 1'b0; mif.v_exp = 1'b0; mif.v_log = 1'b0;
    mif.oC_mac = '0; mif.oC_div = '0; mif.oC_exp = '0; mif.oC_log = '0;
  endtask

  // Every accepted output transfer must match the oldest expected capture.
  always @(negedge clk) begin
    if (mon_on && !rst && mif.oC_valid && mif.oC_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: output lane0=%h with no expected entry", mif.oC[0]);
      end else begin
        lanes_t e;
        e = sb.pop_front();
        if (mif.oC !== e) begin
          errors++;
          $display("FAIL sb_data: lane0 got %h want %h, lane%0d got %h want %h",
                   mif.oC[0], e[0], LN - 1, mif.oC[LN-1], e[LN-1]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; idle(); mif.mode = 2'd0;
    mif.v_mac = 1'b1; mif.oC_mac = mk(0, 99); mif.oC_ready = 1'b1;
    #1;
    checks++; if (rdys() !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b want 0000", rdys()); end
    tick();
    tick();
    checks++; if (rdys() !== 4'b0000) begin errors++; $display("FAIL reset_rdy_held: got %b want 0000", rdys()); end
    checks++; if (mif.oC_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mif.oC_valid); end
    checks++; if (mif.oC !== '0) begin errors++; $display("FAIL reset_oc: lane0 got %h want 0", mif.oC[0]); end
    checks++; if (mif.mode_q !== 2'd0) begin errors++; $display("FAIL reset_mode_q: got %0d want 0", mif.mode_q); end
    checks++; if (mif.switch_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", mif.switch_pend); end
    checks++; if (mif.stray_err !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b want 0", mif.stray_err); end
    checks++; if (mif.res_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", mif.res_cnt); end
    rst = 1'b0; idle(); mif.oC_ready = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_stream();
    mif.mode = 2'd0; mif.oC_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      mif.v_mac = 1'b1; mif.oC_mac = mk(0, k);
      #1;
      checks++; if (mif.r_mac !== 1'b1) begin errors++; $display("FAIL stream_rdy%0d: got %b want 1", k, mif.r_mac); end
      sb.push_back(mk(0, k));
      tick();
      checks++;
      if (mif.oC_valid !== 1'b1 || mif.oC[0] !== BW'(k)) begin
        errors++; $display("FAIL stream_lat%0d: valid %b lane0 %h, want valid 1 lane0 %h", k, mif.oC_valid, mif.oC[0], BW'(k));
      end
    end
    idle();
    tick();
    checks++; if (mif.oC_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", mif.oC_valid); end
    checks++; if (mif.res_cnt !== 16'd4) begin errors++; $display("FAIL stream_cnt: got %0d want 4", mif.res_cnt); end
  endtask

  task automatic test_backpressure();
    lanes_t a, b;
    a = mk(0, 10); b = mk(0, 11);
    mif.oC_ready = 1'b0; mif.v_mac = 1'b1; mif.oC_mac = a;
    #1;
    checks++; if (mif.r_mac !== 1'b1) begin errors++; $display("FAIL bp_rdy_empty: got %b want 1", mif.r_mac); end
    sb.push_back(a);
    tick();
    mif.oC_mac = b;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (mif.r_mac !== 1'b0) begin errors++; $display("FAIL bp_rdy_full%0d: got %b want 0", c, mif.r_mac); end
      tick();
      checks++;
      if (mif.oC_valid !== 1'b1 || mif.oC !== a) begin
        errors++; $display("FAIL bp_stable%0d: valid %b lane0 %h, want valid 1 lane0 %h", c, mif.oC_valid, mif.oC[0], a[0]);
      end
    end
    mif.oC_ready = 1'b1;
    #1;
    checks++; if (mif.r_mac !== 1'b1) begin errors++; $display("FAIL bp_rdy_drain: got %b want 1", mif.r_mac); end
    sb.push_back(b);
    tick();
    checks++;
    if (mif.oC_valid !== 1'b1 || mif.oC !== b) begin
      errors++; $display("FAIL bp_swap: valid %b lane0 %h, want valid 1 lane0 %h", mif.oC_valid, mif.oC[0], b[0]);
    end
    idle();
    tick();
    checks++; if (mif.oC_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", mif.oC_valid); end
  endtask

  task automatic test_mode_switch();
    lanes_t d;
    d = mk(2, 21);
    mif.oC_ready = 1'b0; mif.v_mac = 1'b1; mif.oC_mac = mk(0, 20);
    sb.push_back(mk(0, 20));
    tick();
    idle(); mif.mode = 2'd2;
    #1;
    checks++; if (rdys() !== 4'b0000) begin errors++; $display("FAIL sw_rdy_now: got %b want 0000", rdys()); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (mif.switch_pend !== 1'b1 || mif.mode_q !== 2'd0 || rdys() !== 4'b0000) begin
        errors++; $display("FAIL sw_hold%0d: pend %b mode_q %0d rdy %b, want 1 0 0000", c, mif.switch_pend, mif.mode_q, rdys());
      end
    end
    mif.oC_ready = 1'b1;
    #1;
    checks++; if (rdys() !== 4'b0000) begin errors++; $display("FAIL sw_rdy_drain: got %b want 0000", rdys()); end
    tick();
    checks++;
    if (mif.oC_valid !== 1'b0 || mif.switch_pend !== 1'b1) begin
      errors++; $display("FAIL sw_drained: valid %b pend %b, want 0 1", mif.oC_valid, mif.switch_pend);
    end
    tick();
    checks++;
    if (mif.mode_q !== 2'd2 || mif.switch_pend !== 1'b0 || rdys() !== 4'b0100) begin
      errors++; $display("FAIL sw_done: mode_q %0d pend %b rdy %b, want 2 0 0100", mif.mode_q, mif.switch_pend, rdys());
    end
    mif.v_exp = 1'b1; mif.oC_exp = d;
    sb.push_back(d);
    tick();
    checks++; if (mif.oC !== d) begin errors++; $display("FAIL sw_exp_data: lane0 got %h want %h", mif.oC[0], d[0]); end
    idle();
    tick();
    checks++; if (mif.stray_err !== 1'b0) begin errors++; $display("FAIL sw_no_stray: got %b want 0", mif.stray_err); end
  endtask

  task automatic test_switch_back();
    mif.mode = 2'd1;
    tick();
    checks++; if (mif.switch_pend !== 1'b1) begin errors++; $display("FAIL back_pend: got %b want 1", mif.switch_pend); end
    mif.mode = 2'd2;
    tick();
    checks++;
    if (mif.mode_q !== 2'd2 || mif.switch_pend !== 1'b0) begin
      errors++; $display("FAIL back_done: mode_q %0d pend %b, want 2 0", mif.mode_q, mif.switch_pend);
    end
    mif.mode = 2'd1;
    tick();
    tick();
    checks++; if (mif.mode_q !== 2'd1) begin errors++; $display("FAIL back_div: got %0d want 1", mif.mode_q); end
  endtask

  task automatic test_stray();
    mif.oC_ready = 1'b1; mif.v_log = 1'b1; mif.oC_log = mk(3, 30);
    #1;
    checks++; if (rdys() !== 4'b0010) begin errors++; $display("FAIL stray_rdy: got %b want 0010", rdys()); end
    tick();
    idle();
    checks++;
    if (mif.stray_err !== 1'b1 || mif.oC_valid !== 1'b0) begin
      errors++; $display("FAIL stray_set: err %b valid %b, want 1 0", mif.stray_err, mif.oC_valid);
    end
    tick();
    tick();
    checks++; if (mif.stray_err !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b want 1", mif.stray_err); end
  endtask

  task automatic test_wrap_reset();
    rst = 1'b1; mif.mode = 2'd0;
    tick();
    checks++;
    if (mif.stray_err !== 1'b0 || mif.res_cnt !== 16'd0) begin
      errors++; $display("FAIL wrap_pre_rst: err %b cnt %0d, want 0 0", mif.stray_err, mif.res_cnt);
    end
    rst = 1'b0; sb.delete();
    mif.oC_ready = 1'b1; mif.v_mac = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      mif.oC_mac = mk(0, i);
      sb.push_back(mk(0, i));
      tick();
    end
    idle();
    tick();
    checks++; if (mif.res_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_full: got %h want ffff", mif.res_cnt); end
    mif.v_mac = 1'b1; mif.oC_mac = mk(0, 7777);
    sb.push_back(mk(0, 7777));
    tick();
    idle();
    tick();
    checks++; if (mif.res_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", mif.res_cnt); end

    mif.mode = 2'd2;
    tick();
    tick();
    checks++; if (mif.mode_q !== 2'd2) begin errors++; $display("FAIL rst_pre_mode: got %0d want 2", mif.mode_q); end
    mif.oC_ready = 1'b0; mif.v_exp = 1'b1; mif.oC_exp = mk(2, 40);
    tick();
    checks++; if (mif.oC_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", mif.oC_valid); end
    rst = 1'b1; mif.oC_ready = 1'b1; mif.mode = 2'd0;
    #1;
    checks++; if (rdys() !== 4'b0000) begin errors++; $display("FAIL rst_rdy: got %b want 0000", rdys()); end
    tick();
    checks++;
    if (mif.oC_valid !== 1'b0 || mif.mode_q !== 2'd0 || mif.oC !== '0 || mif.res_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_flight: valid %b mode_q %0d lane0 %h cnt %0d, want 0 0 0 0",
                         mif.oC_valid, mif.mode_q, mif.oC[0], mif.res_cnt);
    end
    rst = 1'b0; idle(); mif.oC_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_mode_switch();
    test_switch_back();
    test_stray();
    test_wrap_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d entries never delivered, want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
